// File: rtl/heap_pkg.sv
// Shared constants and types for the RV32 heap-instruction decoder and its
// command queue.
package heap_pkg;

  localparam logic [6:0] CUSTOM_OPCODE = 7'b0001011;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_PUSH  = 3'b000;
  localparam logic [2:0] F3_POP   = 3'b001;
  localparam logic [2:0] F3_PEEK  = 3'b010;
  localparam logic [2:0] F3_CLEAR = 3'b011;

  typedef enum logic [1:0] {
    PUSH  = 2'd0,
    POP   = 2'd1,
    PEEK  = 2'd2,
    CLEAR = 2'd3
  } heap_op_t;

  // Command layout for the default datapath; the top builds a width-matched
  // copy from its own XLEN/NUM_HEAPS.
  typedef struct packed {
    heap_op_t    op;
    logic [1:0]  heap_id;
    logic [31:0] data;
    logic [4:0]  rd;
  } heap_cmd_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        is_heap;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/heap_cmd_fifo.sv
// Power-of-two FIFO with occupancy count; read data is taken straight from
// storage at the read pointer.
module heap_cmd_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/heap_cmd_decode.sv
// Registered RV32 field/immediate decoder that recognises custom-0 heap
// instructions and queues them as heap-unit commands.
module heap_cmd_decode #(
  parameter  int unsigned XLEN          = 32,
  parameter  int unsigned NUM_HEAPS     = 4,
  parameter  int unsigned FIFO_DEPTH    = 4,
  parameter  logic [6:0]  CUSTOM_OPCODE = heap_pkg::CUSTOM_OPCODE,
  localparam int unsigned HID_W         = $clog2(NUM_HEAPS),
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1_val,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [6:0]       dec_opcode,
  output logic [2:0]       dec_funct3,
  output logic [6:0]       dec_funct7,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  output logic [4:0]       dec_rd,
  output logic [31:0]      dec_imm,
  output logic             dec_is_heap,
  output logic             dec_illegal,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [HID_W-1:0] cmd_heap_id,
  output logic [XLEN-1:0]  cmd_data,
  output logic [4:0]       cmd_rd,
  output logic [CNT_W-1:0] cmd_count
);

  import heap_pkg::*;

  typedef struct packed {
    heap_op_t         op;
    logic [HID_W-1:0] heap_id;
    logic [XLEN-1:0]  data;
    logic [4:0]       rd;
  } cmd_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d        = '0;
    d.opcode = i[6:0];
    d.rd     = i[11:7];
    d.funct3 = i[14:12];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.funct7 = i[31:25];
    if (d.opcode != CUSTOM_OPCODE) begin
      case (d.opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: d.imm = {{20{i[31]}}, i[31:20]};
        OPC_STORE:  d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        OPC_BRANCH: d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        OPC_LUI, OPC_AUIPC: d.imm = {i[31:12], 12'b0};
        OPC_JAL:    d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        default:    d.imm = '0;
      endcase
    end else begin
      // Shift rather than slice so the upper-bits check also holds at HID_W = 7.
      d.is_heap = (d.funct3 <= F3_CLEAR) && ((d.funct7 >> HID_W) == '0);
      d.illegal = !d.is_heap;
    end
    return d;
  endfunction

  dec_t dec_next;
  dec_t dec_q;
  cmd_t cmd_in;
  cmd_t cmd_out;
  logic accept;
  logic enq;
  logic deq;

  assign in_ready = (!dec_valid || dec_ready) && (cmd_count != CNT_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign dec_next = decode(in_instr);
  assign enq      = accept && dec_next.is_heap;
  assign deq      = cmd_valid && cmd_ready;

  always_comb begin
    cmd_in         = '0;
    cmd_in.op      = heap_op_t'(dec_next.funct3[1:0]);
    cmd_in.heap_id = dec_next.funct7[HID_W-1:0];
    cmd_in.data    = in_rs1_val;
    cmd_in.rd      = dec_next.rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_q     <= '0;
    end else if (accept) begin
      dec_valid <= 1'b1;
      dec_q     <= dec_next;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  assign dec_opcode  = dec_q.opcode;
  assign dec_funct3  = dec_q.funct3;
  assign dec_funct7  = dec_q.funct7;
  assign dec_rs1     = dec_q.rs1;
  assign dec_rs2     = dec_q.rs2;
  assign dec_rd      = dec_q.rd;
  assign dec_imm     = dec_q.imm;
  assign dec_is_heap = dec_q.is_heap;
  assign dec_illegal = dec_q.illegal;

  heap_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data (cmd_in),
    .rd_en   (deq),
    .rd_data (cmd_out),
    .count   (cmd_count)
  );

  assign cmd_valid   = (cmd_count != '0);
  assign cmd_op      = cmd_out.op;
  assign cmd_heap_id = cmd_out.heap_id;
  assign cmd_data    = cmd_out.data;
  assign cmd_rd      = cmd_out.rd;

endmodule
